uart_reg_cmd_ctrl: RTL and testbench

Command sequencer between the UART byte stream and the 32-entry UART register block. It parses framed read/write commands from received bytes and drives the register block's STATE_W/STATE_R/ADDR/DATA_IN/STATE_FAIL strobes. It checks the block's OK/FAIL result and serialises a response back to the UART transmitter. It is the only master of the register block.

---
 rtl/uart_reg_cmd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_reg_cmd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the 32-entry register block.
// Parses 'W'/'R' frames, strobes the register block and serialises the OK/ERR response.
module uart_reg_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int REG_DEPTH      = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        STATE_W,
    output logic        STATE_R,
    output logic [7:0]  ADDR,
    output logic [31:0] DATA_IN,
    output logic        STATE_FAIL,
    input  logic [31:0] REG_DATA_OUT,
    input  logic        REG_OK,
    input  logic        REG_FAIL,
    output logic        BUSY
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [8:0]       ADDR_LIMIT = 9'(REG_DEPTH);
    localparam logic [7:0]       CMD_W      = 8'h57;
    localparam logic [7:0]       CMD_R      = 8'h52;
    localparam logic [7:0]       RESP_OK    = 8'h4B;
    localparam logic [7:0]       RESP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_ISSUE, S_WAIT, S_ERR, S_RESP
    } state_t;

    state_t           state_reg, state_next;
    logic             op_write_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       byte_idx_reg;
    logic [2:0]       tx_idx_reg;
    logic             resp_err_reg;
    logic [31:0]      rd_data_reg;
    logic [7:0]       addr_reg;
    logic [31:0]      data_in_reg;

    logic             timed;
    logic             timeout_hit;
    logic             addr_bad;
    logic             reg_bad;
    logic [2:0]       tx_last;
    logic [7:0]       rd_byte [4];

    assign timed       = (state_reg == S_GET_ADDR) || (state_reg == S_GET_DATA);
    // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1; a byte in that cycle wins.
    assign timeout_hit = (cnt_reg == CNT_LAST) && !RX_VALID;
    assign addr_bad    = {1'b0, RX_DATA} >= ADDR_LIMIT;
    assign reg_bad     = REG_FAIL || !REG_OK;
    assign tx_last     = (resp_err_reg || op_write_reg) ? 3'd0 : 3'd4;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign rd_byte[gi] = rd_data_reg[31-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (RX_VALID) begin
                    state_next = (RX_DATA == CMD_W || RX_DATA == CMD_R) ? S_GET_ADDR : S_ERR;
                end
            end
            S_GET_ADDR: begin
                if (RX_VALID) begin
                    if (addr_bad)          state_next = S_ERR;
                    else if (op_write_reg) state_next = S_GET_DATA;
                    else                   state_next = S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_GET_DATA: begin
                if (RX_VALID) begin
                    if (byte_idx_reg == 2'd3) state_next = S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = reg_bad ? S_ERR : S_RESP;
            S_ERR:   state_next = S_RESP;
            S_RESP: begin
                if (TX_READY && tx_idx_reg == tx_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_write_reg <= 1'b0;
            cnt_reg      <= '0;
            byte_idx_reg <= 2'd0;
            tx_idx_reg   <= 3'd0;
            resp_err_reg <= 1'b0;
            rd_data_reg  <= 32'd0;
            addr_reg     <= 8'd0;
            data_in_reg  <= 32'd0;
        end else begin
            cnt_reg <= (timed && !RX_VALID) ? cnt_reg + CNT_W'(1) : '0;
            case (state_reg)
                S_IDLE: begin
                    if (RX_VALID) op_write_reg <= (RX_DATA == CMD_W);
                end
                S_GET_ADDR: begin
                    if (RX_VALID) begin
                        addr_reg     <= RX_DATA;
                        byte_idx_reg <= 2'd0;
                    end
                end
                S_GET_DATA: begin
                    if (RX_VALID) begin
                        data_in_reg  <= {data_in_reg[23:0], RX_DATA};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                    end
                end
                S_WAIT: begin
                    resp_err_reg <= reg_bad;
                    tx_idx_reg   <= 3'd0;
                    if (!reg_bad && !op_write_reg) rd_data_reg <= REG_DATA_OUT;
                end
                S_ERR: begin
                    resp_err_reg <= 1'b1;
                    tx_idx_reg   <= 3'd0;
                end
                S_RESP: begin
                    if (TX_READY) tx_idx_reg <= tx_idx_reg + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        STATE_W    = (state_reg == S_ISSUE) && op_write_reg;
        STATE_R    = (state_reg == S_ISSUE) && !op_write_reg;
        STATE_FAIL = (state_reg == S_ERR);
        BUSY       = (state_reg != S_IDLE);
        TX_VALID   = (state_reg == S_RESP);
        ADDR       = addr_reg;
        DATA_IN    = data_in_reg;
        TX_DATA    = 8'h00;
        if (state_reg == S_RESP) begin
            case (tx_idx_reg)
                3'd0:    TX_DATA = resp_err_reg ? RESP_ERR : RESP_OK;
                3'd1:    TX_DATA = rd_byte[0];
                3'd2:    TX_DATA = rd_byte[1];
                3'd3:    TX_DATA = rd_byte[2];
                3'd4:    TX_DATA = rd_byte[3];
                default: TX_DATA = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Directed bench for uart_reg_cmd_ctrl with a small register-block model.
module tb_uart_reg_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        STATE_W, STATE_R, STATE_FAIL, BUSY;
    logic [7:0]  ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] REG_DATA_OUT = 32'd0;
    logic        REG_OK = 1'b0;
    logic        REG_FAIL = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic        model_fail;
    logic        mem_clr;
    logic [31:0] mem [32];
    int          w_cnt = 0, r_cnt = 0, f_cnt = 0, txv_cnt = 0;
    logic        count_tx;
    logic        excl_bad = 1'b0;
    logic        prev_strobe = 1'b0;

    always #5 CLK = ~CLK;

    uart_reg_cmd_ctrl #(.TIMEOUT_CYCLES(16), .REG_DEPTH(32)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .STATE_W(STATE_W), .STATE_R(STATE_R), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .STATE_FAIL(STATE_FAIL), .REG_DATA_OUT(REG_DATA_OUT), .REG_OK(REG_OK),
        .REG_FAIL(REG_FAIL), .BUSY(BUSY)
    );

    // Register block model: results visible the cycle after the strobe.
    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else begin
            if (STATE_W) mem[ADDR[4:0]] <= DATA_IN;
            if (STATE_R) REG_DATA_OUT <= mem[ADDR[4:0]];
            if (STATE_W || STATE_R) begin
                REG_OK   <= !model_fail;
                REG_FAIL <= model_fail;
            end
        end
    end

    always @(posedge CLK) begin
        if (!RST) begin
            if (STATE_W) w_cnt <= w_cnt + 1;
            if (STATE_R) r_cnt <= r_cnt + 1;
            if (STATE_FAIL) f_cnt <= f_cnt + 1;
            if (count_tx && TX_VALID) txv_cnt <= txv_cnt + 1;
            if ($countones({STATE_W, STATE_R, STATE_FAIL}) > 1) excl_bad <= 1'b1;
            if (prev_strobe && (STATE_W || STATE_R || STATE_FAIL)) excl_bad <= 1'b1;
            prev_strobe <= STATE_W || STATE_R || STATE_FAIL;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_rd [5];
        logic       fail_early;
        logic       hold_valid;
        logic [7:0] hold_byte;
        int         got;

        exp_rd[0] = 8'h4B; exp_rd[1] = 8'hDE; exp_rd[2] = 8'hAD;
        exp_rd[3] = 8'hBE; exp_rd[4] = 8'hEF;

        RST = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00; TX_READY = 1'b0;
        model_fail = 1'b0; mem_clr = 1'b1; count_tx = 1'b0;
        tick(); tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_tx_valid", TX_VALID, 0);
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_data_in", DATA_IN, 0);
        chk("rst_strobes", {STATE_W, STATE_R, STATE_FAIL}, 0);
        mem_clr = 1'b0; RST = 1'b0;
        tick();

        // Write 0xDEADBEEF to address 5 with a held-off transmitter
        send_byte(8'h57);
        chk("wr_busy", BUSY, 1);
        send_byte(8'h05);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("wr_state_w", STATE_W, 1);
        chk("wr_state_r", STATE_R, 0);
        chk("wr_addr", ADDR, 32'h05);
        chk("wr_data_in", DATA_IN, 32'hDEADBEEF);
        tick();
        chk("wr_wait_strobe", STATE_W, 0);
        chk("wr_wait_txv", TX_VALID, 0);
        tick();
        chk("wr_resp_txv", TX_VALID, 1);
        chk("wr_resp_byte", TX_DATA, 32'h4B);
        tick(); tick();
        chk("wr_hold_byte", TX_DATA, 32'h4B);
        chk("wr_hold_txv", TX_VALID, 1);
        TX_READY = 1'b1;
        tick();
        chk("wr_done_txv", TX_VALID, 0);
        chk("wr_done_busy", BUSY, 0);

        // Read back address 5 with TX_READY held high
        send_byte(8'h52);
        send_byte(8'h05);
        chk("rd_state_r", STATE_R, 1);
        tick(); tick();
        chk("rd_b0", TX_DATA, 32'h4B);
        tick(); chk("rd_b1", TX_DATA, 32'hDE);
        tick(); chk("rd_b2", TX_DATA, 32'hAD);
        tick(); chk("rd_b3", TX_DATA, 32'hBE);
        tick(); chk("rd_b4", TX_DATA, 32'hEF);
        tick();
        chk("rd_done_busy", BUSY, 0);

        // Highest legal address reads back zero
        send_byte(8'h52);
        send_byte(8'h1F);
        chk("rd31_state_r", STATE_R, 1);
        tick(); tick();
        chk("rd31_b0", TX_DATA, 32'h4B);
        tick(); chk("rd31_b1", TX_DATA, 32'h00);
        tick(); tick(); tick(); tick();
        chk("rd31_done_busy", BUSY, 0);

        // Unknown command byte
        send_byte(8'h41);
        chk("badcmd_fail", STATE_FAIL, 1);
        tick();
        chk("badcmd_resp", TX_DATA, 32'h45);
        chk("badcmd_strobe_len", STATE_FAIL, 0);
        tick();
        chk("badcmd_done", BUSY, 0);

        // Address 32 is out of range
        send_byte(8'h57);
        send_byte(8'h20);
        chk("badaddr_fail", STATE_FAIL, 1);
        chk("badaddr_no_w", STATE_W, 0);
        tick();
        chk("badaddr_resp", TX_DATA, 32'h45);
        tick();
        chk("badaddr_done", BUSY, 0);

        // Inter-byte timeout: STATE_FAIL 15 cycles after the last byte
        send_byte(8'h57); send_byte(8'h03); send_byte(8'hDE);
        fail_early = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (STATE_FAIL) fail_early = 1'b1;
        end
        chk("to_not_early", fail_early, 0);
        tick();
        chk("to_fail", STATE_FAIL, 1);
        tick();
        chk("to_resp", TX_DATA, 32'h45);
        tick();
        chk("to_done", BUSY, 0);

        // Clean write after the timeout
        send_byte(8'h57); send_byte(8'h07);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("post_to_w", STATE_W, 1);
        chk("post_to_addr", ADDR, 32'h07);
        chk("post_to_data", DATA_IN, 32'h01020304);
        tick(); tick();
        chk("post_to_resp", TX_DATA, 32'h4B);
        tick();

        // A byte arriving on the terminal-count cycle wins over the timeout
        send_byte(8'h57);
        repeat (14) tick();
        send_byte(8'h03);
        chk("term_byte_wins", STATE_FAIL, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("term_w", STATE_W, 1);
        chk("term_data", DATA_IN, 32'h11223344);
        tick(); tick();
        chk("term_resp", TX_DATA, 32'h4B);
        tick();

        // Register block reports FAIL
        model_fail = 1'b1;
        send_byte(8'h52); send_byte(8'h05);
        tick(); tick();
        chk("regfail_fail", STATE_FAIL, 1);
        tick();
        chk("regfail_resp", TX_DATA, 32'h45);
        tick();
        chk("regfail_done", BUSY, 0);
        model_fail = 1'b0;

        // Backpressure read with RX noise during the response
        send_byte(8'h52); send_byte(8'h05);
        got = 0;
        hold_valid = 1'b0;
        hold_byte = 8'h00;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            TX_READY = ((cyc / 3) % 2) == 1;
            RX_VALID = TX_VALID;
            RX_DATA  = 8'h52;
            if (TX_VALID) begin
                if (hold_valid) chk("bp_stable", TX_DATA, hold_byte);
                if (TX_READY) begin
                    chk("bp_byte", TX_DATA, exp_rd[got]);
                    got++;
                end
            end
            hold_valid = TX_VALID && !TX_READY;
            hold_byte  = TX_DATA;
            tick();
        end
        RX_VALID = 1'b0;
        RX_DATA = 8'h00;
        chk("bp_count", got, 5);
        chk("bp_rx_ignored", BUSY, 0);

        // Reset in the middle of a frame
        TX_READY = 1'b0;
        send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_data_busy", BUSY, 0);
        chk("rst_mid_data_din", DATA_IN, 0);
        chk("rst_mid_data_addr", ADDR, 0);
        tick();
        RST = 1'b0;
        tick();

        // Reset while a response is pending
        send_byte(8'h52); send_byte(8'h05);
        tick(); tick();
        chk("rst_resp_pre_txv", TX_VALID, 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_resp_txv", TX_VALID, 0);
        chk("rst_resp_txd", TX_DATA, 0);
        chk("rst_resp_busy", BUSY, 0);
        tick();
        RST = 1'b0;
        TX_READY = 1'b1;
        count_tx = 1'b1;
        repeat (10) tick();
        count_tx = 1'b0;
        chk("rst_no_stray_tx", txv_cnt, 0);

        // Normal frame after reset
        send_byte(8'h52); send_byte(8'h05);
        chk("post_rst_r", STATE_R, 1);
        tick(); tick();
        chk("post_rst_b0", TX_DATA, 32'h4B);
        tick();
        chk("post_rst_b1", TX_DATA, 32'hDE);
        tick(); tick(); tick(); tick();
        chk("post_rst_done", BUSY, 0);

        chk("strobe_excl", excl_bad, 0);
        chk("w_pulses", w_cnt, 3);
        chk("r_pulses", r_cnt, 6);
        chk("fail_pulses", f_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
